// File: rtl/hba_master_cmd.sv
// Command-stream HBA bus master: turns {cmd, reg[, data]} byte frames into bus transfers and streams read data back.
// Optional slave-ack timeout enabled by defining HBA_MASTER_TIMEOUT_EN.
module hba_master_cmd #(
    parameter int DBUS_WIDTH        = 8,
    parameter int PERIPH_ADDR_WIDTH = 4,
    parameter int REG_ADDR_WIDTH    = 8,
    parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                  hba_clk,
    input  logic                  hba_reset_n,
    input  logic [DBUS_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [DBUS_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  hba_select,
    output logic                  hba_rnw,
    output logic [ADDR_WIDTH-1:0] hba_abus,
    output logic [DBUS_WIDTH-1:0] hba_dbus,
    input  logic [DBUS_WIDTH-1:0] slave_dbus,
    input  logic                  slave_xferack
);

    typedef enum logic [2:0] {
        S_CMD   = 3'd0,
        S_RADDR = 3'd1,
        S_WDATA = 3'd2,
        S_XFER  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [7:0]            TMO_LIMIT = 8'(TIMEOUT_CYCLES);
    localparam logic [DBUS_WIDTH-1:0] TMO_BYTE  = DBUS_WIDTH'(8'hEE);

    state_t r_state, w_state_nxt;

    logic                         r_cmd_rnw, w_cmd_rnw_nxt;
    logic [PERIPH_ADDR_WIDTH-1:0] r_periph,  w_periph_nxt;
    logic [REG_ADDR_WIDTH-1:0]    r_reg,     w_reg_nxt;
    logic [DBUS_WIDTH-1:0]        r_wdata,   w_wdata_nxt;

    logic                  r_rx_ready,   w_rx_ready_nxt;
    logic                  r_tx_valid,   w_tx_valid_nxt;
    logic [DBUS_WIDTH-1:0] r_tx_data,    w_tx_data_nxt;
    logic                  r_hba_select, w_hba_select_nxt;
    logic                  r_hba_rnw,    w_hba_rnw_nxt;
    logic [ADDR_WIDTH-1:0] r_hba_abus,   w_hba_abus_nxt;
    logic [DBUS_WIDTH-1:0] r_hba_dbus,   w_hba_dbus_nxt;

    logic w_rx_fire;
    logic w_tx_fire;
    logic w_tmo_expire;

    assign w_rx_fire = rx_valid & r_rx_ready;
    assign w_tx_fire = r_tx_valid & tx_ready;

`ifdef HBA_MASTER_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;

    // Held at zero outside XFER, so every transfer starts counting from zero.
    always_ff @(posedge hba_clk or negedge hba_reset_n) begin
        if (!hba_reset_n) begin
            r_tmo_cnt <= 8'd0;
        end else if (r_state != S_XFER) begin
            r_tmo_cnt <= 8'd0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end
    end

    assign w_tmo_expire = (r_state == S_XFER) && ((r_tmo_cnt + 8'd1) == TMO_LIMIT);
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^TMO_LIMIT;
    assign w_tmo_expire = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_cmd_rnw_nxt = r_cmd_rnw;
        w_periph_nxt  = r_periph;
        w_reg_nxt     = r_reg;
        w_wdata_nxt   = r_wdata;
        w_tx_data_nxt = r_tx_data;

        case (r_state)
            S_CMD: begin
                if (w_rx_fire) begin
                    w_cmd_rnw_nxt = rx_data[DBUS_WIDTH-1];
                    w_periph_nxt  = rx_data[PERIPH_ADDR_WIDTH-1:0];
                    w_state_nxt   = S_RADDR;
                end
            end
            S_RADDR: begin
                if (w_rx_fire) begin
                    w_reg_nxt   = rx_data[REG_ADDR_WIDTH-1:0];
                    w_state_nxt = r_cmd_rnw ? S_XFER : S_WDATA;
                end
            end
            S_WDATA: begin
                if (w_rx_fire) begin
                    w_wdata_nxt = rx_data;
                    w_state_nxt = S_XFER;
                end
            end
            S_XFER: begin
                // A real ack on the expiry edge takes priority over the timeout byte.
                if (slave_xferack) begin
                    if (r_cmd_rnw) w_tx_data_nxt = slave_dbus;
                    w_state_nxt = r_cmd_rnw ? S_RESP : S_CMD;
                end else if (w_tmo_expire) begin
                    if (r_cmd_rnw) w_tx_data_nxt = TMO_BYTE;
                    w_state_nxt = r_cmd_rnw ? S_RESP : S_CMD;
                end
            end
            S_RESP: begin
                if (w_tx_fire) w_state_nxt = S_CMD;
            end
            default: w_state_nxt = S_CMD;
        endcase

        // Outputs are registered from the next state so they line up with it.
        w_rx_ready_nxt   = (w_state_nxt == S_CMD) || (w_state_nxt == S_RADDR) ||
                           (w_state_nxt == S_WDATA);
        w_tx_valid_nxt   = (w_state_nxt == S_RESP);
        w_hba_select_nxt = (w_state_nxt == S_XFER);
        w_hba_abus_nxt   = w_hba_select_nxt ? {w_periph_nxt, w_reg_nxt} : '0;
        w_hba_dbus_nxt   = (w_hba_select_nxt && !w_cmd_rnw_nxt) ? w_wdata_nxt : '0;
        w_hba_rnw_nxt    = w_hba_select_nxt ? w_cmd_rnw_nxt : r_hba_rnw;
    end

    always_ff @(posedge hba_clk or negedge hba_reset_n) begin
        if (!hba_reset_n) begin
            r_state      <= S_CMD;
            r_rx_ready   <= 1'b0;
            r_tx_valid   <= 1'b0;
            r_tx_data    <= '0;
            r_hba_select <= 1'b0;
            r_hba_rnw    <= 1'b0;
            r_hba_abus   <= '0;
            r_hba_dbus   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rx_ready   <= w_rx_ready_nxt;
            r_tx_valid   <= w_tx_valid_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_hba_select <= w_hba_select_nxt;
            r_hba_rnw    <= w_hba_rnw_nxt;
            r_hba_abus   <= w_hba_abus_nxt;
            r_hba_dbus   <= w_hba_dbus_nxt;
        end
    end

    // Command fields are only consumed after the state machine has loaded them.
    always_ff @(posedge hba_clk) begin
        r_cmd_rnw <= w_cmd_rnw_nxt;
        r_periph  <= w_periph_nxt;
        r_reg     <= w_reg_nxt;
        r_wdata   <= w_wdata_nxt;
    end

    assign rx_ready   = r_rx_ready;
    assign tx_valid   = r_tx_valid;
    assign tx_data    = r_tx_data;
    assign hba_select = r_hba_select;
    assign hba_rnw    = r_hba_rnw;
    assign hba_abus   = r_hba_abus;
    assign hba_dbus   = r_hba_dbus;

endmodule

// File: tb/tb_hba_master_cmd.sv
// Bench for hba_master_cmd: table of command frames with expected bus/response values, plus reset and timeout sequences.
module tb_hba_master_cmd;

    logic        hba_clk = 1'b0;
    logic        hba_reset_n = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        hba_select;
    logic        hba_rnw;
    logic [11:0] hba_abus;
    logic [7:0]  hba_dbus;
    logic [7:0]  slave_dbus = 8'h00;
    logic        slave_xferack = 1'b0;

    hba_master_cmd #(
        .DBUS_WIDTH(8),
        .PERIPH_ADDR_WIDTH(4),
        .REG_ADDR_WIDTH(8),
        .ADDR_WIDTH(12),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .hba_clk(hba_clk),
        .hba_reset_n(hba_reset_n),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .hba_select(hba_select),
        .hba_rnw(hba_rnw),
        .hba_abus(hba_abus),
        .hba_dbus(hba_dbus),
        .slave_dbus(slave_dbus),
        .slave_xferack(slave_xferack)
    );

    always #5 hba_clk = ~hba_clk;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  rdata;
        int          dly;
        int          hold;
        bit          gap;
        logic        rnw;
        logic [11:0] abus;
        logic [7:0]  dbus;
        logic [7:0]  tx;
    } vec_t;

    typedef struct {
        logic        rnw;
        logic [11:0] abus;
        logic [7:0]  dbus;
    } bus_t;

    bus_t       q_bus[$];
    logic [7:0] q_tx[$];
    vec_t       vecs[6];
    int         n_chk = 0;
    int         n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge following acceptance.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && t < 50) begin
            @(negedge hba_clk);
            t++;
        end
        if (!rx_ready) check("rx_ready_wait", 32'(rx_ready), 32'd1);
        @(posedge hba_clk);
        @(negedge hba_clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic tx_accept();
        tx_ready = 1'b1;
        @(posedge hba_clk);
        @(negedge hba_clk);
        tx_ready = 1'b0;
        check("tx_after_accept", {tx_valid, rx_ready}, 2'b01);
    endtask

    task automatic run_vec(input vec_t v);
        bus_t       e;
        logic [7:0] etx;
        q_bus.push_back('{v.rnw, v.abus, v.dbus});
        if (v.rnw) q_tx.push_back(v.tx);
        send_byte(v.b0);
        if (v.gap) @(negedge hba_clk);
        send_byte(v.b1);
        if (!v.rnw) begin
            if (v.gap) @(negedge hba_clk);
            send_byte(v.b2);
        end
        e = q_bus.pop_front();
        check("select_rise", {hba_select, rx_ready, tx_valid}, 3'b100);
        check("xfer_bus", {hba_rnw, hba_abus, hba_dbus}, {e.rnw, e.abus, e.dbus});
        for (int i = 0; i < v.dly; i++) begin
            @(posedge hba_clk);
            @(negedge hba_clk);
            check("xfer_hold", {hba_select, rx_ready, hba_rnw, hba_abus, hba_dbus},
                  {1'b1, 1'b0, e.rnw, e.abus, e.dbus});
        end
        slave_dbus    = v.rdata;
        slave_xferack = 1'b1;
        @(posedge hba_clk);
        @(negedge hba_clk);
        slave_xferack = 1'b0;
        slave_dbus    = 8'h00;
        check("post_ack_bus", {hba_select, hba_rnw, hba_abus, hba_dbus}, {1'b0, e.rnw, 12'h000, 8'h00});
        if (v.rnw) begin
            etx = q_tx.pop_front();
            check("resp", {tx_valid, rx_ready, tx_data}, {1'b1, 1'b0, etx});
            for (int i = 0; i < v.hold; i++) begin
                @(posedge hba_clk);
                @(negedge hba_clk);
                check("resp_hold", {tx_valid, rx_ready, hba_select, tx_data}, {1'b1, 1'b0, 1'b0, etx});
            end
            tx_accept();
        end else begin
            check("write_done", {tx_valid, rx_ready}, 2'b01);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int cnt;
        vec_t vr;
        //          b0     b1     b2     rdata  dly hold gap rnw   abus     dbus   tx
        vecs[0] = '{8'h00, 8'h01, 8'h0F, 8'h00, 3,  0,   0,  1'b0, 12'h001, 8'h0F, 8'h00};
        vecs[1] = '{8'h80, 8'h00, 8'h00, 8'h05, 3,  0,   0,  1'b1, 12'h000, 8'h00, 8'h05};
        vecs[2] = '{8'h83, 8'hA5, 8'h00, 8'hC3, 0,  10,  0,  1'b1, 12'h3A5, 8'h00, 8'hC3};
        vecs[3] = '{8'h7F, 8'hFF, 8'hA5, 8'h00, 1,  0,   0,  1'b0, 12'hFFF, 8'hA5, 8'h00};
        vecs[4] = '{8'hF2, 8'h10, 8'h00, 8'hFF, 5,  2,   0,  1'b1, 12'h210, 8'h00, 8'hFF};
        vecs[5] = '{8'h01, 8'h80, 8'h5A, 8'h00, 2,  0,   1,  1'b0, 12'h180, 8'h5A, 8'h00};

        #1 hba_reset_n = 1'b0;
        @(posedge hba_clk);
        @(posedge hba_clk);
        #1 check("reset_outputs", {rx_ready, tx_valid, tx_data, hba_select, hba_rnw, hba_abus, hba_dbus}, 32'd0);
        @(negedge hba_clk);
        hba_reset_n = 1'b1;
        #1 check("rx_ready_before_edge", 32'(rx_ready), 32'd0);
        @(negedge hba_clk);
        check("rx_ready_after_release", {rx_ready, tx_valid, hba_select}, 3'b100);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].gap) begin
                slave_xferack = 1'b1;
                slave_dbus    = 8'h99;
                repeat (3) @(negedge hba_clk);
                check("spurious_ack_idle", {hba_select, rx_ready, tx_valid, hba_abus}, {3'b010, 12'h000});
                slave_xferack = 1'b0;
                slave_dbus    = 8'h00;
            end
            run_vec(vecs[i]);
        end

`ifdef HBA_MASTER_TIMEOUT_EN
        q_tx.push_back(8'hEE);
        send_byte(8'h87);
        send_byte(8'h33);
        check("tmo_bus", {hba_select, hba_rnw, hba_abus}, {1'b1, 1'b1, 12'h733});
        cnt = 0;
        while (hba_select && cnt < 100) begin
            cnt++;
            @(posedge hba_clk);
            @(negedge hba_clk);
        end
        check("tmo_select_cycles", cnt, 16);
        check("tmo_resp", {tx_valid, tx_data}, {1'b1, q_tx.pop_front()});
        tx_accept();
`endif

        send_byte(8'h85);
        send_byte(8'h42);
        check("pre_reset_select", {hba_select, hba_abus}, {1'b1, 12'h542});
        @(posedge hba_clk);
        #2 hba_reset_n = 1'b0;
        #1 check("async_reset_outputs", {rx_ready, tx_valid, tx_data, hba_select, hba_rnw, hba_abus, hba_dbus}, 32'd0);
        @(negedge hba_clk);
        hba_reset_n = 1'b1;
        @(negedge hba_clk);
        check("rx_ready_after_reset2", {rx_ready, hba_select}, 2'b10);
        vr = '{8'h02, 8'h34, 8'h77, 8'h00, 1, 0, 0, 1'b0, 12'h234, 8'h77, 8'h00};
        run_vec(vr);

        check("queues_empty", {q_bus.size() == 0, q_tx.size() == 0}, 2'b11);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hba_master_cmd.md
# hba_master_cmd

Command-stream bus master for the HBA bus. Consumes a byte stream (from the host serial receiver) encoding register read/write commands, drives HBA bus transactions to slave peripherals such as the GPIO block, and returns read data as a byte stream to the host serial transmitter. It is the single bus master sitting upstream of every HBA peripheral.

## Interface
- DBUS_WIDTH, 8, bus data width; fixed at 8 (one stream byte per data word)
- PERIPH_ADDR_WIDTH, 4, peripheral-select field width of hba_abus
- REG_ADDR_WIDTH, 8, register field width of hba_abus
- ADDR_WIDTH, PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH, total bus address width
- TIMEOUT_CYCLES, 255, slave-ack timeout in clocks; 1..255; used only with HBA_MASTER_TIMEOUT_EN

Ports:
- hba_clk  in  1  single clock; all logic on rising edge
- hba_reset_n  in  1  reset, asynchronous assert, active-low
- rx_data  in  8  command stream byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  block accepts rx_data this cycle
- tx_data  out  8  response byte
- tx_valid  out  1  tx_data valid; held until accepted
- tx_ready  in  1  downstream accepts tx_data
- hba_select  out  1  bus transfer in progress
- hba_rnw  out  1  1=read, 0=write
- hba_abus  out  ADDR_WIDTH  {periph, reg} address
- hba_dbus  out  8  write data to slaves
- slave_dbus  in  8  OR of all slave data buses (zero when idle)
- slave_xferack  in  1  OR of all slave xferack signals

## Operation
- Stream byte accepted on a clock edge where rx_valid & rx_ready; tx byte accepted where tx_valid & tx_ready.
- Command framing: byte 0 = {rnw, 3'b000 ignored, periph[3:0]}; byte 1 = reg address; byte 2 = write data (writes only).
- States: CMD -> RADDR -> (rnw ? XFER : WDATA -> XFER) -> (rnw ? RESP : CMD); RESP -> CMD on tx accept.
- CMD/RADDR/WDATA: rx_ready=1; each accepted byte latched (cmd, reg, data); gaps in rx_valid simply hold state.
- XFER: rx_ready=0; hba_select=1, hba_rnw, hba_abus={periph,reg}, hba_dbus=data (0 for reads) all stable for the whole transfer. Leaves XFER on the edge slave_xferack is sampled 1; read data captured from slave_dbus on that same edge.
- RESP: tx_valid=1, tx_data=captured byte, held stable until tx_ready; rx_ready=0.
- Writes produce no response byte.
- hba_select, hba_abus, hba_dbus return to 0 in every state other than XFER; hba_rnw holds last value.
- slave_xferack outside XFER is ignored.

## Timing
- Reset (async, hba_reset_n=0): state=CMD, rx_ready=0, tx_valid=0, tx_data=0, hba_select=0, hba_rnw=0, hba_abus=0, hba_dbus=0, timeout counter=0. rx_ready rises on first clock edge after reset release.
- Reset mid-transfer: hba_select drops immediately (asynchronously); partially received command discarded.
- All outputs registered.
- Final command byte accepted at edge N -> hba_select=1 from edge N (visible cycle N+1).
- slave_xferack sampled 1 at edge M -> hba_select=0 after M; read: tx_valid=1 after M; write: rx_ready=1 after M.
- tx accepted at edge K -> tx_valid=0, rx_ready=1 after K.
- Minimum write: 3 rx cycles + slave latency + 1; back-to-back commands need no idle gap beyond that.

## Configuration
- HBA_MASTER_TIMEOUT_EN defined: 8-bit counter clears on XFER entry, increments each XFER cycle; when it reaches TIMEOUT_CYCLES with no ack, transfer aborts exactly as if acked: hba_select drops; reads return byte 0xEE in RESP; writes return to CMD silently. An ack arriving on the same edge as expiry wins (real data).
- Undefined: no counter; XFER waits indefinitely for slave_xferack.

## Test plan
- Write 0x00,0x01,0x0F (periph 0, reg 1, data 0x0F) -> one XFER with hba_rnw=0, hba_abus=0x001, hba_dbus=0x0F until slave ack; no tx byte; rx_ready returns.
- Read 0x80,0x00 with slave returning 0x05 with xferack 3 cycles later -> hba_abus=0x000, hba_rnw=1; tx_data=0x05 with tx_valid the cycle after ack.
- Read with tx_ready held 0 for 10 cycles -> tx_valid and tx_data=value stable throughout, rx_ready=0; single transfer on tx_ready.
- rx_valid toggling every other cycle over a write command plus spurious slave_xferack while in CMD -> exactly one correct bus transfer; spurious ack ignored.
- HBA_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, read to unmapped periph 0x7 -> hba_select high exactly 16 cycles, tx_data=0xEE.
- Assert hba_reset_n low during XFER -> hba_select=0 immediately, all outputs at reset values; next command after release executes normally.
